// File: rtl/evt_xbar_cfg_sequencer.sv
// evt_xbar_cfg_sequencer
// Holds the shadow and active routing tables for a two-stage synaptic crossbar
// and runs the commit sequence: gate the crossbar sources, wait until every mid
// FIFO has been idle for QUIET consecutive cycles, then copy shadow->active in a
// single cycle. If the drain does not settle within TIMEOUT cycles, the commit
// is aborted and the active tables are left untouched.
//
// Gating handshake: while gate_o=1 the crossbar sources hold their valid low.
// Transfers that already had valid&ready asserted when the gate rose are allowed
// to finish. busy_i reports those in-flight transfers and any non-empty FIFO.
// The swap happens only after busy_i has been zero for QUIET cycles in a row.
module evt_xbar_cfg_sequencer #(
    parameter int N0      = 12,
    parameter int W0      = 3,
    parameter int N1      = 8,
    parameter int W1      = 3,
    parameter int NB      = 8,
    parameter int QUIET   = 2,
    parameter int TIMEOUT = 255,
    localparam int NMAX   = (N0 > N1) ? N0 : N1,
    localparam int WMAX   = (W0 > W1) ? W0 : W1,
    localparam int IW     = (NMAX > 1) ? $clog2(NMAX) : 1,
    localparam int TW     = $clog2(TIMEOUT + 1),
    localparam int QW     = $clog2(QUIET + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic               wr_stage_i,
    input  logic [IW-1:0]      wr_idx_i,
    input  logic [WMAX-1:0]    wr_data_i,
    input  logic               commit_req_i,
    input  logic [NB-1:0]      busy_i,
    output logic [N0*W0-1:0]   cfg_stage0_o,
    output logic [N1*W1-1:0]   cfg_stage1_o,
    output logic               gate_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_timeout_o,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GATE    = 3'd1,
        S_DRAIN   = 3'd2,
        S_SWAP    = 3'd3,
        S_RELEASE = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N0*W0-1:0]   r_sh0;
    logic [N1*W1-1:0]   r_sh1;
    logic [N0*W0-1:0]   r_act0;
    logic [N1*W1-1:0]   r_act1;
    logic [QW-1:0]      r_quiet_cnt;
    logic [TW-1:0]      r_to_cnt;
    logic               r_err;
    logic               w_all_idle;
    logic               w_quiet_hit;
    logic               w_to_hit;

    assign w_all_idle  = (busy_i == '0);
    assign w_quiet_hit = w_all_idle && (r_quiet_cnt == QW'(QUIET - 1));
    assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a quiet window that completes wins over a same-cycle timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (commit_req_i) w_next = S_GATE;
            S_GATE:    w_next = S_DRAIN;
            S_DRAIN: begin
                if (w_quiet_hit) begin
                    w_next = S_SWAP;
                end else if (w_to_hit) begin
                    w_next = S_ABORT;
                end
            end
            S_SWAP:    w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            S_ABORT:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        gate_o = 1'b0;
        busy_o = 1'b1;
        done_o = 1'b0;
        case (r_state)
            S_IDLE:                   busy_o = 1'b0;
            S_GATE, S_DRAIN, S_SWAP:  gate_o = 1'b1;
            S_RELEASE, S_ABORT:       done_o = 1'b1;
            default:                  busy_o = 1'b1;
        endcase
    end

    // Drain counters: cleared in GATE, saturating while in DRAIN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_quiet_cnt <= '0;
            r_to_cnt    <= '0;
        end else if (r_state == S_GATE) begin
            r_quiet_cnt <= '0;
            r_to_cnt    <= '0;
        end else if (r_state == S_DRAIN) begin
            if (r_to_cnt != TW'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (!w_all_idle) begin
                r_quiet_cnt <= '0;
            end else if (r_quiet_cnt != QW'(QUIET)) begin
                r_quiet_cnt <= r_quiet_cnt + 1'b1;
            end
        end
    end

    // Shadow tables: host writes in any state, out-of-range indices match no entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < N0; i++) begin
                if (!wr_stage_i && (wr_idx_i == IW'(i))) begin
                    r_sh0[i*W0 +: W0] <= wr_data_i[W0-1:0];
                end
            end
            for (int j = 0; j < N1; j++) begin
                if (wr_stage_i && (wr_idx_i == IW'(j))) begin
                    r_sh1[j*W1 +: W1] <= wr_data_i[W1-1:0];
                end
            end
        end
    end

    // Active tables: copied from the shadow only in SWAP; a same-cycle write stays in the shadow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_act0 <= '0;
            r_act1 <= '0;
        end else if (r_state == S_SWAP) begin
            r_act0 <= r_sh0;
            r_act1 <= r_sh1;
        end
    end

    // Sticky timeout flag: set on entering ABORT, cleared when the next commit is accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && commit_req_i) begin
            r_err <= 1'b0;
        end else if ((r_state == S_DRAIN) && (w_next == S_ABORT)) begin
            r_err <= 1'b1;
        end
    end

    assign cfg_stage0_o  = r_act0;
    assign cfg_stage1_o  = r_act1;
    assign err_timeout_o = r_err;
    assign dbg_state_o   = r_state;

endmodule
